udp_recv_mp: RTL and testbench
==============================

Name: udp_recv_mp

Overview:
- Parametrised multi-port successor to the single-port UDP header parser.
- Sits after ip_recv in the Ethernet receive path and consumes the UDP header plus payload byte stream.
- Filters packets by destination IP, broadcast and DHCP rules, then decodes the destination port against a contiguous table of NUM_PORTS listening ports.
- Qualifies each payload byte with first/last/index markers; checks the UDP length field; reports completion, errors and drop statistics.

Parameters:
- NUM_PORTS, 4, number of contiguous listening ports starting at PORT_BASE (1..16).
- PORT_BASE, 1024, first listening UDP port.
- BCAST_PORT, 1024, only port accepted for broadcast packets.
- DHCP_PORT, 68, port treated as DHCP when dhcp_enable=1.
- LEN_W, 11, width of length and byte counters.
- CNT_W, 16, width of drop/error statistics counters.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- rx_enable  in  1  high while UDP bytes of one packet are presented; low between packets.
- data  in  8  UDP byte, valid when rx_enable=1.
- to_ip  in  32  destination IP of current packet, from ip_recv.
- broadcast  in  1  current packet was broadcast.
- dhcp_enable  in  1  DHCP client running.
- remote_mac  in  48  source MAC of current packet.
- remote_ip  in  32  source IP of current packet.
- local_ip  in  32  this board's IP.
- active  out  1  current data byte is accepted non-DHCP payload (combinational, same cycle as byte).
- dhcp_active  out  1  current data byte is DHCP payload.
- payload_first  out  1  with active/dhcp_active, first payload byte.
- payload_last  out  1  with active/dhcp_active, final payload byte.
- port_hit  out  NUM_PORTS  one-hot listening-port match, held for the packet.
- port_index  out  4  binary index of the match, 0 if no match.
- to_port  out  16  destination port.
- udp_destination_ip  out  32  latched reply IP.
- udp_destination_mac  out  48  latched reply MAC.
- udp_destination_port  out  16  latched reply port (source port).
- pkt_done  out  1  one-cycle pulse: accepted packet's last payload byte consumed.
- len_error  out  1  one-cycle pulse: illegal length or truncated packet.
- drop_count  out  CNT_W  packets filtered out, wraps.
- err_count  out  CNT_W  len_error events, wraps.

Behaviour:
- Reset values: all registered outputs are 0, state=IDLE. Active/first/last outputs are 0 because state≠PAYLOAD.
- States: IDLE, PORT, HDR, PAYLOAD, DONE.
- Header byte numbering 1..8: source port 1-2, destination port 3-4, length 5-6, checksum 7-8. The checksum is ignored.
- IDLE: with rx_enable, latch src_port[15:8] and clear the dhcp flag -> PORT.
- PORT: latch src_port[7:0], byte_no=3 -> HDR.
- HDR byte 5 filter, first match wins:
  - to_port==DHCP_PORT and dhcp_enable: set dhcp flag.
  - else broadcast and to_port≠BCAST_PORT: drop.
  - else not broadcast and to_ip≠local_ip: drop.
  - A drop goes to DONE and increments drop_count once.
- HDR byte 5 port decode: port_hit[i]=1 iff to_port==PORT_BASE+i. Unicast packets to other ports are still accepted with port_hit=0 and port_index=0.
- HDR byte 6: compute length. If length<8, pulse len_error, increment err_count -> DONE.
- HDR byte 8: latch remote_ip, remote_mac and src_port into the udp_destination_* outputs.
  - If length==8 (empty payload), pulse pkt_done and go to DONE; active never asserts.
  - Otherwise go to PAYLOAD.
- PAYLOAD covers bytes 9..length. active (or dhcp_active if the dhcp flag is set) is high on each. payload_first is high on byte 9; payload_last is high on byte==length.
  - On byte==length, pulse pkt_done the next cycle -> DONE.
  - Bytes after length (Ethernet CRC/padding) stay in DONE with no outputs.
- rx_enable low in any state returns to IDLE next edge. If rx_enable falls in PAYLOAD before byte==length, pulse len_error and increment err_count.
- Reset overrides rx_enable and aborts any packet without pulses or count changes.
- byte_no is LEN_W bits; the length field uses its low LEN_W bits. A length exceeding 2^LEN_W-1 is an error at byte 6.
- Counter increment and reset in the same cycle: reset wins.
- Only one of active and dhcp_active is ever high.

Test Plan:
- Unicast to local_ip, dst port 1026, length 12, payload A1..A4 -> active on 4 bytes, first on A1, last on A4, port_hit=0100, port_index=2, pkt_done once, udp_destination_port=src port.
- Broadcast to port 1024 then broadcast to port 5000 -> first accepted with port_hit=0001; second never active, drop_count=1.
- dhcp_enable=1, dst 68, length 10 -> dhcp_active on 2 bytes, active stays 0; with dhcp_enable=0 and to_ip≠local_ip -> drop_count increments.
- Length field 6 -> len_error pulse at byte 6, err_count=1, no active. Length 8 -> pkt_done, no active.
- rx_enable dropped after 2 of 4 payload bytes -> len_error pulse, state IDLE; next valid packet is parsed correctly.
- Reset asserted mid-payload -> active=0 next cycle, all outputs and counters 0. Trailing 4 CRC bytes after the last payload byte produce no active.

Source files
------------

// File: rtl/udp_recv_mp.sv
// udp_recv_mp : multi-port UDP header parser and payload qualifier.
//
// Consumes the UDP header + payload byte stream delivered by ip_recv while
// rx_enable is high. Filters on destination IP / broadcast / DHCP rules,
// decodes the destination port against NUM_PORTS contiguous listening ports
// starting at PORT_BASE, flags payload bytes and checks the length field.
//
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   rx_enable, data         byte stream of one packet (rx_enable low between packets)
//   to_ip, broadcast        destination IP / broadcast flag of the packet
//   dhcp_enable             DHCP client running
//   remote_mac, remote_ip   source addresses of the packet
//   local_ip                this board's IP
//   active, dhcp_active     current byte is payload (normal / DHCP), combinational
//   payload_first/_last     first / final payload byte markers, combinational
//   port_hit, port_index    one-hot / binary listening-port match, held per packet
//   to_port                 destination port
//   udp_destination_*       latched reply address (source IP/MAC/port)
//   pkt_done, len_error     one-cycle completion / length-error pulses
//   drop_count, err_count   wrapping statistics counters
module udp_recv_mp #(
   parameter int NUM_PORTS  = 4,
   parameter int PORT_BASE  = 1024,
   parameter int BCAST_PORT = 1024,
   parameter int DHCP_PORT  = 68,
   parameter int LEN_W      = 11,
   parameter int CNT_W      = 16
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 rx_enable,
   input  logic [7:0]           data,
   input  logic [31:0]          to_ip,
   input  logic                 broadcast,
   input  logic                 dhcp_enable,
   input  logic [47:0]          remote_mac,
   input  logic [31:0]          remote_ip,
   input  logic [31:0]          local_ip,
   output logic                 active,
   output logic                 dhcp_active,
   output logic                 payload_first,
   output logic                 payload_last,
   output logic [NUM_PORTS-1:0] port_hit,
   output logic [3:0]           port_index,
   output logic [15:0]          to_port,
   output logic [31:0]          udp_destination_ip,
   output logic [47:0]          udp_destination_mac,
   output logic [15:0]          udp_destination_port,
   output logic                 pkt_done,
   output logic                 len_error,
   output logic [CNT_W-1:0]     drop_count,
   output logic [CNT_W-1:0]     err_count
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_PORT    = 3'd1,
      S_HDR     = 3'd2,
      S_PAYLOAD = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   localparam logic [15:0] LEN_MAX = 16'((32'd1 << LEN_W) - 32'd1);

   state_t               state, state_nx;
   logic [LEN_W-1:0]     byte_no_r;
   logic [LEN_W-1:0]     len_r;
   logic [7:0]           len_hi_r;
   logic [15:0]          src_port_r;
   logic                 dhcp_flag_r;
   logic [15:0]          len_field;
   logic                 dhcp_match, filter_drop, len_bad;
   logic                 drop_ev, lenerr_ev, done_ev;
   logic [NUM_PORTS-1:0] hit_vec;
   logic [3:0]           hit_idx;

   // Length field is complete when its low byte is on the bus (byte 6);
   // anything beyond the byte counter range is treated as illegal.
   assign len_field = {len_hi_r, data};
   assign len_bad   = (len_field < 16'd8) || (len_field > LEN_MAX);

   // DHCP acceptance takes precedence over the address filters.
   assign dhcp_match  = (to_port == 16'(DHCP_PORT)) && dhcp_enable;
   assign filter_drop = !dhcp_match &&
                        ((broadcast && (to_port != 16'(BCAST_PORT))) ||
                         (!broadcast && (to_ip != local_ip)));

   // Listening-port decode: one-hot vector plus its binary index.
   always_comb begin
      hit_vec = '0;
      hit_idx = 4'd0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (to_port == 16'(PORT_BASE + i)) begin
            hit_vec[i] = 1'b1;
            hit_idx    = 4'(i);
         end else begin
            hit_vec[i] = 1'b0;
         end
      end
   end

   // FSM state register.
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // FSM next-state logic and per-byte events.
   always_comb begin
      state_nx  = state;
      drop_ev   = 1'b0;
      lenerr_ev = 1'b0;
      done_ev   = 1'b0;
      if (!rx_enable) begin
         state_nx = S_IDLE;
         // The FSM leaves PAYLOAD on the final byte, so still being here
         // when the stream stops means the packet was truncated.
         if (state == S_PAYLOAD) begin
            lenerr_ev = 1'b1;
         end else begin
            lenerr_ev = 1'b0;
         end
      end else begin
         case (state)
            S_IDLE:  state_nx = S_PORT;
            S_PORT:  state_nx = S_HDR;
            S_HDR: begin
               if ((byte_no_r == LEN_W'(5)) && filter_drop) begin
                  state_nx = S_DONE;
                  drop_ev  = 1'b1;
               end else if ((byte_no_r == LEN_W'(6)) && len_bad) begin
                  state_nx  = S_DONE;
                  lenerr_ev = 1'b1;
               end else if (byte_no_r == LEN_W'(8)) begin
                  if (len_r == LEN_W'(8)) begin
                     state_nx = S_DONE;
                     done_ev  = 1'b1;
                  end else begin
                     state_nx = S_PAYLOAD;
                  end
               end else begin
                  state_nx = S_HDR;
               end
            end
            S_PAYLOAD: begin
               if (byte_no_r == len_r) begin
                  state_nx = S_DONE;
                  done_ev  = 1'b1;
               end else begin
                  state_nx = S_PAYLOAD;
               end
            end
            S_DONE:  state_nx = S_DONE;
            default: state_nx = S_IDLE;
         endcase
      end
   end

   // FSM outputs: payload qualifiers for the byte currently on the bus.
   always_comb begin
      active        = 1'b0;
      dhcp_active   = 1'b0;
      payload_first = 1'b0;
      payload_last  = 1'b0;
      if ((state == S_PAYLOAD) && rx_enable) begin
         active        = !dhcp_flag_r;
         dhcp_active   = dhcp_flag_r;
         payload_first = (byte_no_r == LEN_W'(9));
         payload_last  = (byte_no_r == len_r);
      end else begin
         active = 1'b0;
      end
   end

   // Header capture, byte counter, pulses and statistics.
   always_ff @(posedge clock) begin
      if (reset) begin
         byte_no_r            <= '0;
         len_r                <= '0;
         len_hi_r             <= 8'd0;
         src_port_r           <= 16'd0;
         dhcp_flag_r          <= 1'b0;
         port_hit             <= '0;
         port_index           <= 4'd0;
         to_port              <= 16'd0;
         udp_destination_ip   <= 32'd0;
         udp_destination_mac  <= 48'd0;
         udp_destination_port <= 16'd0;
         pkt_done             <= 1'b0;
         len_error            <= 1'b0;
         drop_count           <= '0;
         err_count            <= '0;
      end else begin
         pkt_done  <= done_ev;
         len_error <= lenerr_ev;
         if (drop_ev) begin
            drop_count <= drop_count + CNT_W'(1);
         end else begin
            drop_count <= drop_count;
         end
         if (lenerr_ev) begin
            err_count <= err_count + CNT_W'(1);
         end else begin
            err_count <= err_count;
         end
         if (rx_enable) begin
            case (state)
               S_IDLE: begin
                  src_port_r[15:8] <= data;
                  dhcp_flag_r      <= 1'b0;
                  port_hit         <= '0;
                  port_index       <= 4'd0;
               end
               S_PORT: begin
                  src_port_r[7:0] <= data;
                  byte_no_r       <= LEN_W'(3);
               end
               S_HDR: begin
                  byte_no_r <= byte_no_r + LEN_W'(1);
                  case (byte_no_r)
                     LEN_W'(3): to_port[15:8] <= data;
                     LEN_W'(4): to_port[7:0]  <= data;
                     LEN_W'(5): begin
                        len_hi_r    <= data;
                        dhcp_flag_r <= dhcp_match;
                        port_hit    <= hit_vec;
                        port_index  <= hit_idx;
                     end
                     LEN_W'(6): len_r <= len_field[LEN_W-1:0];
                     LEN_W'(8): begin
                        udp_destination_ip   <= remote_ip;
                        udp_destination_mac  <= remote_mac;
                        udp_destination_port <= src_port_r;
                     end
                     default: len_hi_r <= len_hi_r;
                  endcase
               end
               S_PAYLOAD: byte_no_r <= byte_no_r + LEN_W'(1);
               default:   byte_no_r <= byte_no_r;
            endcase
         end else begin
            byte_no_r <= byte_no_r;
         end
      end
   end

endmodule

// File: tb/tb_udp_recv_mp.sv
// Self-checking bench for udp_recv_mp: a packet-level model predicts, for
// every cycle of a packet, the payload flags, pulses and counters; one
// compare process checks the DUT against it on every falling edge.
module tb_udp_recv_mp;

   localparam logic [31:0] LOCAL = 32'hC0A8_0010;
   localparam logic [31:0] OTHER = 32'hC0A8_0099;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        rx_enable = 1'b0;
   logic [7:0]  data = 8'h00;
   logic [31:0] to_ip = 32'h0;
   logic        broadcast = 1'b0;
   logic        dhcp_enable = 1'b0;
   logic [47:0] remote_mac = 48'h0;
   logic [31:0] remote_ip = 32'h0;
   logic [31:0] local_ip = LOCAL;
   logic        active, dhcp_active, payload_first, payload_last;
   logic [3:0]  port_hit, port_index;
   logic [15:0] to_port, udp_destination_port;
   logic [31:0] udp_destination_ip;
   logic [47:0] udp_destination_mac;
   logic        pkt_done, len_error;
   logic [15:0] drop_count, err_count;

   always #5 clock = ~clock;

   udp_recv_mp dut (
      .clock(clock), .reset(reset), .rx_enable(rx_enable), .data(data),
      .to_ip(to_ip), .broadcast(broadcast), .dhcp_enable(dhcp_enable),
      .remote_mac(remote_mac), .remote_ip(remote_ip), .local_ip(local_ip),
      .active(active), .dhcp_active(dhcp_active),
      .payload_first(payload_first), .payload_last(payload_last),
      .port_hit(port_hit), .port_index(port_index), .to_port(to_port),
      .udp_destination_ip(udp_destination_ip),
      .udp_destination_mac(udp_destination_mac),
      .udp_destination_port(udp_destination_port),
      .pkt_done(pkt_done), .len_error(len_error),
      .drop_count(drop_count), .err_count(err_count)
   );

   int compared = 0;
   int mismatched = 0;
   int act_seen = 0;
   int dact_seen = 0;

   // model expectations for the cycle currently being presented
   logic        checking = 1'b0;
   logic        e_act = 1'b0, e_dact = 1'b0, e_first = 1'b0, e_last = 1'b0;
   logic        e_done = 1'b0, e_lerr = 1'b0, chk_zero = 1'b0;
   logic [15:0] m_drop = 16'd0, m_err = 16'd0;
   logic [3:0]  e_hit = 4'd0, e_idx = 4'd0;
   logic [15:0] e_to_port = 16'd0, e_dport = 16'd0;
   logic [31:0] e_dip = 32'd0;
   logic [47:0] e_dmac = 48'd0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      compared++;
      if (got !== want) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
      end
   endtask

   // single compare process
   always @(negedge clock) begin
      if (checking) begin
         chk("active", 64'(active), 64'(e_act));
         chk("dhcp_active", 64'(dhcp_active), 64'(e_dact));
         chk("payload_first", 64'(payload_first), 64'(e_first));
         chk("payload_last", 64'(payload_last), 64'(e_last));
         chk("pkt_done", 64'(pkt_done), 64'(e_done));
         chk("len_error", 64'(len_error), 64'(e_lerr));
         chk("drop_count", 64'(drop_count), 64'(m_drop));
         chk("err_count", 64'(err_count), 64'(m_err));
         if (active) act_seen++;
         if (dhcp_active) dact_seen++;
         if (e_done) begin
            chk("port_hit", 64'(port_hit), 64'(e_hit));
            chk("port_index", 64'(port_index), 64'(e_idx));
            chk("to_port", 64'(to_port), 64'(e_to_port));
            chk("dest_ip", 64'(udp_destination_ip), 64'(e_dip));
            chk("dest_mac", 64'(udp_destination_mac), 64'(e_dmac));
            chk("dest_port", 64'(udp_destination_port), 64'(e_dport));
         end
         if (chk_zero) begin
            chk("zero_port_hit", 64'(port_hit), 64'd0);
            chk("zero_port_index", 64'(port_index), 64'd0);
            chk("zero_to_port", 64'(to_port), 64'd0);
            chk("zero_dest_ip", 64'(udp_destination_ip), 64'd0);
            chk("zero_dest_mac", 64'(udp_destination_mac), 64'd0);
            chk("zero_dest_port", 64'(udp_destination_port), 64'd0);
         end
      end
   end

   // Drive one packet of n bytes (then 4 idle cycles); rst_at>0 asserts
   // reset while byte rst_at is presented.
   task automatic run_pkt(input logic [15:0] src, input logic [15:0] dst,
                          input logic [15:0] len, input int n, input logic bc,
                          input logic [31:0] dip, input logic dh, input int rst_at);
      logic [7:0] pk [1:48];
      bit ea [1:56], ed [1:56], ef [1:56], el [1:56];
      int T, drop_at, err_at, done_at;
      bit is_dhcp, drop, lenbad;
      T = n + 4;
      drop_at = 0; err_at = 0; done_at = 0;
      pk[1] = src[15:8]; pk[2] = src[7:0];
      pk[3] = dst[15:8]; pk[4] = dst[7:0];
      pk[5] = len[15:8]; pk[6] = len[7:0];
      pk[7] = 8'h00;     pk[8] = 8'h00;
      for (int k = 9; k <= n; k++)
         pk[k] = (k <= int'(len)) ? 8'(8'hA0 + k - 8) : 8'hCC;
      for (int k = 1; k <= T; k++) begin
         ea[k] = 1'b0; ed[k] = 1'b0; ef[k] = 1'b0; el[k] = 1'b0;
      end
      // packet-level decision
      is_dhcp = (dst == 16'd68) && dh;
      drop    = !is_dhcp && (bc ? (dst != 16'd1024) : (dip != LOCAL));
      lenbad  = (len < 16'd8) || (len > 16'd2047);
      if (drop) drop_at = 6;
      else if (lenbad) err_at = 7;
      else begin
         for (int k = 9; k <= n && k <= int'(len); k++) begin
            if (is_dhcp) ed[k] = 1'b1; else ea[k] = 1'b1;
            ef[k] = (k == 9);
            el[k] = (k == int'(len));
         end
         if (n >= int'(len)) done_at = int'(len) + 1;
         else err_at = n + 2;
      end
      if (rst_at > 0) begin
         for (int k = rst_at + 1; k <= T; k++) begin
            ea[k] = 1'b0; ed[k] = 1'b0; ef[k] = 1'b0; el[k] = 1'b0;
         end
         if (drop_at > rst_at) drop_at = 0;
         if (err_at > rst_at) err_at = 0;
         if (done_at > rst_at) done_at = 0;
      end
      e_hit     = (dst >= 16'd1024 && dst < 16'd1028) ? (4'd1 << (dst - 16'd1024)) : 4'd0;
      e_idx     = (dst >= 16'd1024 && dst < 16'd1028) ? 4'(dst - 16'd1024) : 4'd0;
      e_to_port = dst;
      e_dport   = src;
      e_dip     = 32'h0A00_0000 | {16'd0, src};
      e_dmac    = 48'h02AB_0000_0000 | {32'd0, src};
      for (int k = 1; k <= T; k++) begin
         @(posedge clock);
         #1;
         reset       = (k == rst_at);
         rx_enable   = (k <= n);
         data        = (k <= n) ? pk[k] : 8'h00;
         to_ip       = dip;
         broadcast   = bc;
         dhcp_enable = dh;
         remote_ip   = e_dip;
         remote_mac  = e_dmac;
         e_act   = ea[k]; e_dact = ed[k]; e_first = ef[k]; e_last = el[k];
         e_done  = (k == done_at);
         e_lerr  = (k == err_at);
         if (k == drop_at) m_drop = m_drop + 16'd1;
         if (k == err_at)  m_err  = m_err + 16'd1;
         chk_zero = (rst_at > 0) && (k == rst_at + 1);
         if (chk_zero) begin
            m_drop = 16'd0;
            m_err  = 16'd0;
         end
      end
      chk_zero = 1'b0;
      @(negedge clock);
      #1;
   endtask

   initial begin
      // reset state
      @(posedge clock);
      #1;
      checking = 1'b1;
      chk_zero = 1'b1;
      @(posedge clock);
      #1;
      reset    = 1'b0;
      chk_zero = 1'b0;

      // unicast, port 1026, length 12, followed by 4 CRC bytes
      act_seen = 0;
      run_pkt(16'h1234, 16'd1026, 16'd12, 16, 1'b0, LOCAL, 1'b0, 0);
      chk("t1_active_bytes", 64'(act_seen), 64'd4);
      chk("t1_port_index", 64'(port_index), 64'd2);
      chk("t1_port_hit", 64'(port_hit), 64'h4);
      chk("t1_reply_port", 64'(udp_destination_port), 64'h1234);

      // broadcast to 1024 accepted, broadcast to 5000 dropped
      run_pkt(16'h0101, 16'd1024, 16'd10, 10, 1'b1, OTHER, 1'b0, 0);
      act_seen = 0;
      run_pkt(16'h0202, 16'd5000, 16'd10, 10, 1'b1, OTHER, 1'b0, 0);
      chk("t2_drop_count", 64'(drop_count), 64'd1);
      chk("t2_no_active", 64'(act_seen), 64'd0);

      // DHCP accepted although to_ip is foreign; then dropped when disabled
      act_seen = 0; dact_seen = 0;
      run_pkt(16'd67, 16'd68, 16'd10, 10, 1'b0, OTHER, 1'b1, 0);
      chk("t3_dhcp_bytes", 64'(dact_seen), 64'd2);
      chk("t3_no_active", 64'(act_seen), 64'd0);
      run_pkt(16'd67, 16'd68, 16'd10, 10, 1'b0, OTHER, 1'b0, 0);
      chk("t3_drop_count", 64'(drop_count), 64'd2);

      // illegal length 6, oversize length, then empty payload
      act_seen = 0;
      run_pkt(16'h0303, 16'd1025, 16'd6, 8, 1'b0, LOCAL, 1'b0, 0);
      chk("t4_err_count", 64'(err_count), 64'd1);
      run_pkt(16'h0404, 16'd1025, 16'd3000, 8, 1'b0, LOCAL, 1'b0, 0);
      run_pkt(16'h0505, 16'd1025, 16'd8, 8, 1'b0, LOCAL, 1'b0, 0);
      chk("t4_no_active", 64'(act_seen), 64'd0);
      chk("t4_err_count2", 64'(err_count), 64'd2);

      // truncated after 2 of 4 payload bytes, then a clean packet
      run_pkt(16'h0606, 16'd1024, 16'd12, 10, 1'b0, LOCAL, 1'b0, 0);
      chk("t5_err_count", 64'(err_count), 64'd3);
      run_pkt(16'h0707, 16'd1027, 16'd9, 9, 1'b0, LOCAL, 1'b0, 0);
      chk("t5_port_index", 64'(port_index), 64'd3);

      // reset in the middle of the payload
      run_pkt(16'h0808, 16'd1025, 16'd12, 11, 1'b0, LOCAL, 1'b0, 11);
      chk("t6_drop_count", 64'(drop_count), 64'd0);
      chk("t6_err_count", 64'(err_count), 64'd0);

      checking = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
